mem_port_arbiter: RTL and testbench

//  Shares one byte-wide main-memory port between the CPU instruction fetch (32-bit word = 4 byte beats)
//  and the CPU data access (single-byte load/store). Sits between cpu/pc and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU fetch port, the CPU data port and the byte-wide memory port of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic [31:0]       I_DATA;
  logic              I_VALID;

  logic              D_READ;
  logic              D_WRITE;
  logic [7:0]        D_ADDR;
  logic [7:0]        D_WDATA;
  logic [7:0]        D_RDATA;
  logic              D_VALID;

  logic              BUSYWAIT;

  logic              M_REQ;
  logic              M_WE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [7:0]        M_WDATA;
  logic [7:0]        M_RDATA;
  logic              M_ACK;

  logic              ERR;

  // Arbiter side: serves the CPU and masters the memory port.
  modport master (
    input  I_REQ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WDATA, M_RDATA, M_ACK,
    output I_DATA, I_VALID, D_RDATA, D_VALID, BUSYWAIT,
           M_REQ, M_WE, M_ADDR, M_WDATA, ERR
  );

  // Environment side: CPU requesters plus the memory model.
  modport slave (
    output I_REQ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WDATA, M_RDATA, M_ACK,
    input  I_DATA, I_VALID, D_RDATA, D_VALID, BUSYWAIT,
           M_REQ, M_WE, M_ADDR, M_WDATA, ERR
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between 4-beat instruction fetches and single-byte data
// accesses, stalling the CPU via BUSYWAIT; data wins over a simultaneous fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                CLK,
  input logic                RESET,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned      TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFETCH = 2'd1;
  localparam logic [1:0] ST_DACC   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        beat_q;
  logic [TO_W-1:0]   wait_q;
  logic              is_fetch_q;
  logic              d_we_q;
  logic [7:0]        d_wdata_q;
  logic [7:0]        d_rdata_q;
  logic [31:0]       i_data_q;
  logic              err_q;

  logic busy_c;
  logic d_req_c;
  logic ack_c;
  logic to_hit_c;

  assign busy_c   = (state_q == ST_IFETCH) || (state_q == ST_DACC);
  assign d_req_c  = bus.D_READ || bus.D_WRITE;
  assign ack_c    = busy_c && bus.M_ACK;
  // Last waiting cycle of a beat passes with no ack: abort the access.
  assign to_hit_c = busy_c && !bus.M_ACK && (wait_q == TO_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req_c) begin
          state_d = ST_DACC;
        end else if (bus.I_REQ) begin
          state_d = ST_IFETCH;
        end
      end
      ST_IFETCH: begin
        if (to_hit_c || (ack_c && (beat_q == 2'd3))) begin
          state_d = ST_RESP;
        end
      end
      ST_DACC: begin
        if (to_hit_c || ack_c) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access context, beat assembly and the per-beat wait counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q     <= '0;
      beat_q     <= 2'd0;
      wait_q     <= '0;
      is_fetch_q <= 1'b0;
      d_we_q     <= 1'b0;
      d_wdata_q  <= 8'h00;
      d_rdata_q  <= 8'h00;
      i_data_q   <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wait_q <= '0;
          beat_q <= 2'd0;
          if (d_req_c) begin
            addr_q     <= ADDR_W'(bus.D_ADDR);
            d_we_q     <= bus.D_WRITE;
            d_wdata_q  <= bus.D_WDATA;
            is_fetch_q <= 1'b0;
          end else if (bus.I_REQ) begin
            addr_q     <= bus.I_ADDR;
            i_data_q   <= 32'h0000_0000;
            is_fetch_q <= 1'b1;
          end
        end
        ST_IFETCH: begin
          if (ack_c) begin
            i_data_q[{beat_q, 3'b000} +: 8] <= bus.M_RDATA;
            beat_q <= beat_q + 2'd1;
            wait_q <= '0;
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
          if (to_hit_c) begin
            err_q <= 1'b1;
          end
        end
        ST_DACC: begin
          if (ack_c) begin
            wait_q <= '0;
            if (!d_we_q) begin
              d_rdata_q <= bus.M_RDATA;
            end
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
          if (to_hit_c) begin
            err_q <= 1'b1;
            if (!d_we_q) begin
              d_rdata_q <= 8'h00;
            end
          end
        end
        default: begin
          wait_q <= '0;
        end
      endcase
    end
  end

  // Memory port is decoded straight from the state and latched context.
  assign bus.M_REQ   = busy_c;
  assign bus.M_WE    = (state_q == ST_DACC) && d_we_q;
  assign bus.M_ADDR  = (state_q == ST_IFETCH) ? (addr_q + ADDR_W'(beat_q)) :
                       (state_q == ST_DACC)   ? addr_q : '0;
  assign bus.M_WDATA = (state_q == ST_DACC) ? d_wdata_q : 8'h00;

  assign bus.I_DATA  = i_data_q;
  assign bus.I_VALID = (state_q == ST_RESP) && is_fetch_q;
  assign bus.D_RDATA = d_rdata_q;
  assign bus.D_VALID = (state_q == ST_RESP) && !is_fetch_q;
  assign bus.ERR     = err_q;

  // A request seen in IDLE stalls the CPU before the state has moved; reset forces the stall low.
  assign bus.BUSYWAIT = !RESET &&
                        (busy_c || ((state_q == ST_IDLE) && (bus.I_REQ || d_req_c)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single accesses plus hand sequences for
// priority, timeout and mid-fetch reset.
module tb_mem_port_arbiter;

  localparam int OP_F  = 0;
  localparam int OP_R  = 1;
  localparam int OP_W  = 2;
  localparam int OP_RW = 3;

  typedef struct {
    int          op;
    logic [9:0]  addr;
    logic [7:0]  wdata;
    int          dly;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic CLK;
  logic RESET;

  mem_port_arbiter_if #(.ADDR_W(10)) bus ();

  mem_port_arbiter #(.ADDR_W(10), .TIMEOUT(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: acks once a beat has waited mem_delay cycles; blk_addr never acks.
  logic [7:0] mem [0:1023];
  int         mem_delay;
  int         dly_cnt;
  logic       blk_en;
  logic [9:0] blk_addr;
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;

  assign bus.M_ACK   = bus.M_REQ && (dly_cnt >= mem_delay) && !(blk_en && (bus.M_ADDR == blk_addr));
  assign bus.M_RDATA = mem[bus.M_ADDR];

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.M_REQ && bus.M_ACK && bus.M_WE) mem[bus.M_ADDR] <= bus.M_WDATA;
  end

  always @(posedge CLK) begin
    dly_cnt <= (bus.M_REQ && !bus.M_ACK) ? dly_cnt + 1 : 0;
  end

  int   total;
  int   bad;
  int   n;
  logic seen;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  task automatic drop_reqs();
    bus.I_REQ = 1'b0; bus.D_READ = 1'b0; bus.D_WRITE = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic got;
    int   lat;
    mem_delay = v.dly;
    @(negedge CLK);
    bus.I_REQ   = (v.op == OP_F);
    bus.I_ADDR  = v.addr;
    bus.D_READ  = (v.op == OP_R) || (v.op == OP_RW);
    bus.D_WRITE = (v.op == OP_W) || (v.op == OP_RW);
    bus.D_ADDR  = v.addr[7:0];
    bus.D_WDATA = v.wdata;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 80) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, 32'(bus.BUSYWAIT), 32'd1);
        check({tag, "_maddr"}, 32'(bus.M_ADDR), 32'(v.addr));
        check({tag, "_mwe"}, 32'(bus.M_WE), 32'((v.op == OP_W) || (v.op == OP_RW)));
      end
      got = (v.op == OP_F) ? bus.I_VALID : bus.D_VALID;
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"}, 32'(lat), 32'(v.lat));
      check({tag, "_resp_busy"}, 32'(bus.BUSYWAIT), 32'd0);
      check({tag, "_resp_mreq"}, 32'(bus.M_REQ), 32'd0);
      if (v.op == OP_F) check({tag, "_idata"}, bus.I_DATA, v.exp);
      else if (v.op == OP_R) check({tag, "_drdata"}, 32'(bus.D_RDATA), v.exp);
    end
    drop_reqs();
    @(posedge CLK); #1;
    check({tag, "_pulse_end"}, 32'(bus.I_VALID || bus.D_VALID), 32'd0);
    if ((v.op == OP_W) || (v.op == OP_RW)) check({tag, "_memw"}, 32'(mem[v.addr]), 32'(v.wdata));
  endtask

  initial begin
    total = 0; bad = 0;
    RESET = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    mem_delay = 0; blk_en = 1'b0; blk_addr = '0;
    bus.I_REQ = 1'b0; bus.I_ADDR = '0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;

    vecs[0] = '{OP_F,  10'h000, 8'h00, 0, 32'h0004_0005, 5};
    vecs[1] = '{OP_R,  10'h010, 8'h00, 0, 32'h0000_00A5, 2};
    vecs[2] = '{OP_W,  10'h020, 8'h3C, 3, 32'h0000_0000, 5};
    vecs[3] = '{OP_R,  10'h020, 8'h00, 0, 32'h0000_003C, 2};
    vecs[4] = '{OP_F,  10'h3FE, 8'h00, 0, 32'h0005_2211, 5};
    vecs[5] = '{OP_F,  10'h100, 8'h00, 2, 32'hEFBE_ADDE, 13};
    vecs[6] = '{OP_R,  10'h010, 8'h00, 1, 32'h0000_00A5, 3};
    vecs[7] = '{OP_RW, 10'h030, 8'h5A, 0, 32'h0000_0000, 2};
    vecs[8] = '{OP_R,  10'h030, 8'h00, 0, 32'h0000_005A, 2};

    poke(10'h000, 8'h05); poke(10'h001, 8'h00); poke(10'h002, 8'h04); poke(10'h003, 8'h00);
    poke(10'h010, 8'hA5); poke(10'h020, 8'h00); poke(10'h030, 8'h00);
    poke(10'h3FE, 8'h11); poke(10'h3FF, 8'h22);
    poke(10'h100, 8'hDE); poke(10'h101, 8'hAD); poke(10'h102, 8'hBE); poke(10'h103, 8'hEF);
    poke(10'h200, 8'h77); poke(10'h201, 8'h99); poke(10'h202, 8'h99); poke(10'h203, 8'h99);

    check("rst_idata", bus.I_DATA, 32'h0);
    check("rst_ivalid", 32'(bus.I_VALID), 32'd0);
    check("rst_dvalid", 32'(bus.D_VALID), 32'd0);
    check("rst_drdata", 32'(bus.D_RDATA), 32'd0);
    check("rst_busy", 32'(bus.BUSYWAIT), 32'd0);
    check("rst_mreq", 32'(bus.M_REQ), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);

    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    check("err_clean", 32'(bus.ERR), 32'd0);

    // Data and fetch requested together: data first, fetch follows.
    mem_delay = 0;
    @(negedge CLK);
    bus.D_READ = 1'b1; bus.D_ADDR = 8'h10; bus.I_REQ = 1'b1; bus.I_ADDR = 10'h000;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) check("prio_maddr", 32'(bus.M_ADDR), 32'h010);
      seen = bus.D_VALID;
    end
    check("prio_dvalid_seen", 32'(seen), 32'd1);
    check("prio_dlat", 32'(n), 32'd2);
    check("prio_drdata", 32'(bus.D_RDATA), 32'hA5);
    check("prio_resp_busy", 32'(bus.BUSYWAIT), 32'd0);
    check("prio_no_ivalid", 32'(bus.I_VALID), 32'd0);
    bus.D_READ = 1'b0;
    @(posedge CLK); #1;
    check("prio_idle_busy", 32'(bus.BUSYWAIT), 32'd1);
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(posedge CLK); #1;
      n++;
      seen = bus.I_VALID;
    end
    check("prio_ivalid_seen", 32'(seen), 32'd1);
    check("prio_ilat", 32'(n), 32'd5);
    check("prio_idata", bus.I_DATA, 32'h0004_0005);
    drop_reqs();
    @(posedge CLK); #1;

    // Beat 1 of a fetch never acked: abort after 16 waiting cycles with partial data.
    blk_en = 1'b1; blk_addr = 10'h201;
    run_vec('{OP_F, 10'h200, 8'h00, 0, 32'h0000_0077, 18}, "tmo");
    check("tmo_err", 32'(bus.ERR), 32'd1);
    blk_en = 1'b0;
    run_vec(vecs[0], "post_tmo");
    check("err_sticky", 32'(bus.ERR), 32'd1);

    // Asynchronous reset in the middle of beat 2.
    mem_delay = 5;
    @(negedge CLK);
    bus.I_REQ = 1'b1; bus.I_ADDR = 10'h000;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(bus.M_REQ && (bus.M_ADDR == 10'h002)) && n < 60);
    check("mid_beat2_reached", 32'(bus.M_ADDR), 32'h002);
    check("mid_partial", bus.I_DATA, 32'h0000_0005);
    #2;
    RESET = 1'b1;
    #1;
    check("mid_rst_mreq", 32'(bus.M_REQ), 32'd0);
    check("mid_rst_busy", 32'(bus.BUSYWAIT), 32'd0);
    check("mid_rst_idata", bus.I_DATA, 32'h0);
    check("mid_rst_err", 32'(bus.ERR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("restart_mreq", 32'(bus.M_REQ), 32'd1);
    check("restart_maddr", 32'(bus.M_ADDR), 32'h000);
    seen = 1'b0; n = 1;
    while (!seen && n < 80) begin
      @(posedge CLK); #1;
      n++;
      seen = bus.I_VALID;
    end
    check("restart_valid_seen", 32'(seen), 32'd1);
    check("restart_lat", 32'(n), 32'd25);
    check("restart_idata", bus.I_DATA, 32'h0004_0005);
    drop_reqs();
    @(posedge CLK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
